// File: rtl/mult_share_sched.sv
// Round-robin scheduler sharing one fixed-latency pipelined multiplier among NREQ requesters.
// A tag pipeline aligned to the multiplier routes each result back to its requester.
module mult_share_sched #(
    parameter int NREQ = 4,
    parameter int XW   = 4,
    parameter int YW   = 20,
    parameter int LAT  = 2,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*XW-1:0]   req_x,
    output logic [NREQ-1:0]      req_ready,
    output logic [XW-1:0]        mul_x,
    input  logic [YW-1:0]        mul_y,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [YW-1:0]        rsp_y,
    output logic                 busy,
    output logic [15:0]          grant_cnt
);

    localparam logic [IDW:0]   NREQ_W = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    logic [IDW-1:0]           rr_ptr_reg;
    logic [15:0]              grant_cnt_reg;
    logic [LAT-1:0]           tag_v_reg;
    logic [LAT-1:0][IDW-1:0]  tag_id_reg;

    logic [IDW-1:0]           cand [NREQ];
    logic [NREQ-1:0]          cand_valid;
    logic                     found;
    logic                     grant;
    logic [IDW-1:0]           winner;

    // Candidate gi is the requester gi places after rr_ptr, wrapping modulo NREQ.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_cand
            logic [IDW:0] sum;
            assign sum            = {1'b0, rr_ptr_reg} + (IDW+1)'(gi);
            assign cand[gi]       = (sum >= NREQ_W) ? IDW'(sum - NREQ_W) : sum[IDW-1:0];
            assign cand_valid[gi] = req_valid[cand[gi]];
        end
    endgenerate

    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && cand_valid[k]) begin
                found  = 1'b1;
                winner = cand[k];
            end
        end
    end

    // No grant may be issued while reset is held, even though reset is asynchronous.
    assign grant = found & ~rst;

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_comb begin
        mul_x = '0;
        if (grant) begin
            mul_x = req_x[winner*XW +: XW];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_reg    <= '0;
            grant_cnt_reg <= '0;
        end else if (grant) begin
            rr_ptr_reg    <= (winner == LAST_ID) ? '0 : winner + 1'b1;
            grant_cnt_reg <= grant_cnt_reg + 16'd1;
        end
    end

    // Tags never stall: the multiplier has no backpressure, so the shift is unconditional.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_v_reg  <= '0;
            tag_id_reg <= '0;
        end else begin
            tag_v_reg[0]  <= grant;
            tag_id_reg[0] <= grant ? winner : '0;
            for (int k = 1; k < LAT; k++) begin
                tag_v_reg[k]  <= tag_v_reg[k-1];
                tag_id_reg[k] <= tag_id_reg[k-1];
            end
        end
    end

    assign rsp_valid = tag_v_reg[LAT-1];
    assign rsp_id    = tag_id_reg[LAT-1];
    assign rsp_y     = mul_y;
    assign busy      = |tag_v_reg;
    assign grant_cnt = grant_cnt_reg;

endmodule

// File: tb/tb_mult_share_sched.sv
// Directed bench for mult_share_sched with a LAT=2 multiply-by-3 model behind mul_x/mul_y.
module tb_mult_share_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_x;
    logic [3:0]  req_ready;
    logic [3:0]  mul_x;
    logic [19:0] mul_y;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [19:0] rsp_y;
    logic        busy;
    logic [15:0] grant_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [19:0] m1 = '0;
    logic [19:0] m2 = '0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        m1 <= 20'(mul_x) * 20'd3;
        m2 <= m1;
    end
    assign mul_y = m2;

    mult_share_sched #(.NREQ(4), .XW(4), .YW(20), .LAT(2), .IDW(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_x(req_x),
        .req_ready(req_ready), .mul_x(mul_x), .mul_y(mul_y),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_y(rsp_y),
        .busy(busy), .grant_cnt(grant_cnt)
    );

    typedef struct {
        logic [3:0]  valid;
        logic [15:0] x;
        logic [3:0]  ready;
        logic [3:0]  mulx;
        logic        rv;
        logic [1:0]  rid;
        logic [19:0] ry;
        logic        busy;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs [28];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        // valid, x, ready, mulx, rv, rid, ry, busy, cnt
        vecs[0]  = '{4'hF, 16'h4321, 4'b0001, 4'h1, 1'b0, 2'd0, 20'd0,  1'b0, 16'd0};
        vecs[1]  = '{4'hF, 16'h4321, 4'b0010, 4'h2, 1'b0, 2'd0, 20'd0,  1'b1, 16'd1};
        vecs[2]  = '{4'hF, 16'h4321, 4'b0100, 4'h3, 1'b1, 2'd0, 20'd3,  1'b1, 16'd2};
        vecs[3]  = '{4'hF, 16'h4321, 4'b1000, 4'h4, 1'b1, 2'd1, 20'd6,  1'b1, 16'd3};
        vecs[4]  = '{4'hF, 16'h4321, 4'b0001, 4'h1, 1'b1, 2'd2, 20'd9,  1'b1, 16'd4};
        vecs[5]  = '{4'h0, 16'h0000, 4'b0000, 4'h0, 1'b1, 2'd3, 20'd12, 1'b1, 16'd5};
        vecs[6]  = '{4'h0, 16'h0000, 4'b0000, 4'h0, 1'b1, 2'd0, 20'd3,  1'b1, 16'd5};
        vecs[7]  = '{4'h0, 16'h0000, 4'b0000, 4'h0, 1'b0, 2'd0, 20'd0,  1'b0, 16'd5};
        vecs[8]  = '{4'h2, 16'h00A0, 4'b0010, 4'hA, 1'b0, 2'd0, 20'd0,  1'b0, 16'd5};
        vecs[9]  = '{4'h0, 16'h0000, 4'b0000, 4'h0, 1'b0, 2'd0, 20'd0,  1'b1, 16'd6};
        vecs[10] = '{4'h0, 16'h0000, 4'b0000, 4'h0, 1'b1, 2'd1, 20'd30, 1'b1, 16'd6};
        vecs[11] = '{4'h0, 16'h0000, 4'b0000, 4'h0, 1'b0, 2'd0, 20'd0,  1'b0, 16'd6};
        vecs[12] = '{4'h4, 16'h0500, 4'b0100, 4'h5, 1'b0, 2'd0, 20'd0,  1'b0, 16'd6};
        vecs[13] = '{4'h9, 16'h7008, 4'b1000, 4'h7, 1'b0, 2'd0, 20'd0,  1'b1, 16'd7};
        vecs[14] = '{4'h9, 16'h7008, 4'b0001, 4'h8, 1'b1, 2'd2, 20'd15, 1'b1, 16'd8};
        vecs[15] = '{4'h9, 16'h7008, 4'b1000, 4'h7, 1'b1, 2'd3, 20'd21, 1'b1, 16'd9};
        vecs[16] = '{4'h0, 16'h0000, 4'b0000, 4'h0, 1'b1, 2'd0, 20'd24, 1'b1, 16'd10};
        vecs[17] = '{4'h0, 16'h0000, 4'b0000, 4'h0, 1'b1, 2'd3, 20'd21, 1'b1, 16'd10};
        vecs[18] = '{4'h0, 16'h0000, 4'b0000, 4'h0, 1'b0, 2'd0, 20'd0,  1'b0, 16'd10};
        vecs[19] = '{4'h8, 16'hF000, 4'b1000, 4'hF, 1'b0, 2'd0, 20'd0,  1'b0, 16'd10};
        vecs[20] = '{4'h0, 16'h0000, 4'b0000, 4'h0, 1'b0, 2'd0, 20'd0,  1'b1, 16'd11};
        vecs[21] = '{4'h1, 16'h0002, 4'b0001, 4'h2, 1'b1, 2'd3, 20'd45, 1'b1, 16'd11};
        vecs[22] = '{4'h0, 16'hFFFF, 4'b0000, 4'h0, 1'b0, 2'd0, 20'd0,  1'b1, 16'd12};
        vecs[23] = '{4'h0, 16'h0000, 4'b0000, 4'h0, 1'b1, 2'd0, 20'd6,  1'b1, 16'd12};
        vecs[24] = '{4'h4, 16'h0300, 4'b0100, 4'h3, 1'b0, 2'd0, 20'd0,  1'b0, 16'd12};
        vecs[25] = '{4'h0, 16'h0000, 4'b0000, 4'h0, 1'b0, 2'd0, 20'd0,  1'b1, 16'd13};
        vecs[26] = '{4'h0, 16'h0000, 4'b0000, 4'h0, 1'b1, 2'd2, 20'd9,  1'b1, 16'd13};
        vecs[27] = '{4'h0, 16'h0000, 4'b0000, 4'h0, 1'b0, 2'd0, 20'd0,  1'b0, 16'd13};

        // Reset state, with every requester asking.
        rst = 1'b1;
        req_valid = 4'hF;
        req_x = 16'h4321;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", 32'(req_ready), 32'h0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_rsp_id", 32'(rsp_id), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_cnt", 32'(grant_cnt), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Full rotation, single requester, pointer wrap, sparse grants.
        for (int i = 0; i < 28; i++) begin
            req_valid = vecs[i].valid;
            req_x     = vecs[i].x;
            #1;
            $display("vec %0d: valid=%b ready=%b mul_x=%h rsp_valid=%b rsp_id=%0d rsp_y=%0d busy=%b cnt=%0d",
                     i, req_valid, req_ready, mul_x, rsp_valid, rsp_id, rsp_y, busy, grant_cnt);
            chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vecs[i].ready));
            chk($sformatf("v%0d_mul_x", i), 32'(mul_x), 32'(vecs[i].mulx));
            chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].rv));
            chk($sformatf("v%0d_rsp_id", i), 32'(rsp_id), 32'(vecs[i].rid));
            if (vecs[i].rv) chk($sformatf("v%0d_rsp_y", i), 32'(rsp_y), 32'(vecs[i].ry));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
            chk($sformatf("v%0d_cnt", i), 32'(grant_cnt), 32'(vecs[i].cnt));
            step();
        end

        // Reset mid-flight: rr_ptr is 3 here, so 4'b0011 grants 0 then 1.
        req_valid = 4'b0011;
        req_x = 16'h0021;
        #1;
        chk("mid_grant0", 32'(req_ready), 32'b0001);
        $display("mid: grant ready=%b", req_ready);
        step();
        #1;
        chk("mid_grant1", 32'(req_ready), 32'b0010);
        $display("mid: grant ready=%b", req_ready);
        step();
        rst = 1'b1;
        req_valid = 4'hF;
        req_x = 16'h4321;
        #1;
        chk("mid_rst_ready", 32'(req_ready), 32'h0);
        chk("mid_rst_mul_x", 32'(mul_x), 32'h0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_cnt", 32'(grant_cnt), 32'h0);
        $display("mid: reset asserted rsp_valid=%b busy=%b cnt=%0d", rsp_valid, busy, grant_cnt);
        step();
        #1;
        chk("mid_rst2_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("mid_rst2_busy", 32'(busy), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // All valid from reset for 65536 grants: rotation 0..3 and counter wrap.
        for (int k = 0; k <= 65536; k++) begin
            #1;
            chk($sformatf("wrap%0d_ready", k), 32'(req_ready), 32'(4'b0001 << (k % 4)));
            chk($sformatf("wrap%0d_cnt", k), 32'(grant_cnt), 32'(k % 65536));
            if (k < 2) begin
                chk($sformatf("wrap%0d_rsp_valid", k), 32'(rsp_valid), 32'h0);
            end
            if (k == 0) chk("wrap0_busy", 32'(busy), 32'h0);
            if (k == 1) chk("wrap1_busy", 32'(busy), 32'h1);
            if (k == 2 || k == 3 || k == 65536) begin
                chk($sformatf("wrap%0d_rsp_valid", k), 32'(rsp_valid), 32'h1);
                chk($sformatf("wrap%0d_rsp_id", k), 32'(rsp_id), 32'((k - 2) % 4));
                chk($sformatf("wrap%0d_rsp_y", k), 32'(rsp_y), 32'(3 * ((k - 2) % 4 + 1)));
                chk($sformatf("wrap%0d_mul_x", k), 32'(mul_x), 32'(k % 4 + 1));
            end
            if (k == 65535 || k == 65536) begin
                $display("wrap %0d: ready=%b cnt=%0h", k, req_ready, grant_cnt);
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
